// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings, FSM states and ALU operations for multicycle_mips
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_SLT, ALU_EQ} alu_op_t;
endpackage

// File: rtl/mips_alu.sv
// mips_alu: combinational 32-bit ADD/SUB/signed SLT/EQ
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y
);
  always_comb
    y = op == ALU_ADD ? a + b :
        op == ALU_SUB ? a - b :
        op == ALU_SLT ? {31'b0, $signed(a) < $signed(b)} :
                        {31'b0, a == b};
endmodule

// File: rtl/multicycle_mips.sv
// multicycle_mips: FSM-sequenced MIPS subset core with handshaked memories; J decoded only when MIPS_MC_JUMP_EN is defined
module multicycle_mips
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ack,
  input  logic [31:0]       inst,
  output logic              data_req,
  output logic              data_wr,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_out,
  input  logic              data_ack,
  input  logic [31:0]       data_in,
  output logic              retire,
  output logic              halted
);
  state_t state, state_n;
  logic [31:0] ir, a, b, imm, alu_q, mdr, alu_b, alu_y, pc4, tgt;
  logic [31:0] rf [32];
  logic [ADDR_W-1:0] pc;
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  logic rtype, is_br, is_j, legal, take;
  alu_op_t alu_op;
  assign {op, rs, rt, rd} = ir[31:11];
  assign fn = ir[5:0];
  assign inst_addr = pc;
  mips_alu u_alu (.a(a), .b(alu_b), .op(alu_op), .y(alu_y));
  always_comb begin
    rtype = op == OP_RTYPE;
    is_br = op == OP_BEQ || op == OP_BNE;
`ifdef MIPS_MC_JUMP_EN
    is_j = op == OP_J;
`else
    is_j = 1'b0;
`endif
    legal = (rtype && (fn == FN_ADD || fn == FN_SUB || fn == FN_SLT)) ||
            op == OP_LW || op == OP_SW || is_br || is_j;
    alu_op = is_br ? ALU_EQ : !rtype ? ALU_ADD : fn == FN_SUB ? ALU_SUB : fn == FN_SLT ? ALU_SLT : ALU_ADD;
    alu_b = rtype || is_br ? b : imm;
    pc4 = 32'(pc) + 32'd4;
    take = is_j || (is_br && (alu_y[0] ^ (op == OP_BNE)));
    tgt = is_j ? {pc4[31:28], ir[25:0], 2'b00} : pc4 + {imm[29:0], 2'b00};
    state_n = state;
    case (state)
      FETCH:   state_n = inst_req && inst_ack ? DECODE : FETCH;
      DECODE:  state_n = legal ? EXEC : HALT;
      EXEC:    state_n = is_br || is_j ? FETCH : rtype ? WB : MEM;
      MEM:     state_n = data_req && data_ack ? (op == OP_SW ? FETCH : WB) : MEM;
      WB:      state_n = FETCH;
      default: state_n = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      inst_req <= 1'b0;
      data_req <= 1'b0;
      data_wr <= 1'b0;
      data_addr <= '0;
      data_out <= '0;
      retire <= 1'b0;
      halted <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state <= state_n;
      // requests are asserted on entry to their state and drop on leaving it
      inst_req <= state_n == FETCH;
      data_req <= state_n == MEM;
      retire <= state_n == FETCH && state != FETCH;
      halted <= state_n == HALT;
      case (state)
        FETCH: if (inst_req && inst_ack) ir <= inst;
        DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
          imm <= {{16{ir[15]}}, ir[15:0]};
        end
        EXEC: begin
          alu_q <= alu_y;
          pc <= take ? ADDR_W'(tgt) : ADDR_W'(pc4);
          if (state_n == MEM) begin
            data_addr <= ADDR_W'(alu_y);
            data_out <= b;
            data_wr <= op == OP_SW;
          end
        end
        MEM: if (data_req && data_ack) mdr <= data_in;
        WB: if ((rtype ? rd : rt) != 5'd0) rf[rtype ? rd : rt] <= rtype ? alu_q : mdr;
        default: ;
      endcase
    end
  end
endmodule
